// File: rtl/parking_pkg.sv
// Shared gate-state and sensor-code definitions for the multi-gate parking lot.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_BA,
    OUT_A
  } gate_state_t;

  // Sensor codes written as {a,b}
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;
  localparam logic [1:0] S_B    = 2'b01;

endpackage

// File: rtl/parking_gate_fsm.sv
// Per-gate direction decoder; optional 2-flop sensor synchroniser under
// PARKING_SENSOR_SYNC_EN.
module parking_gate_fsm
  import parking_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic done_in,
  output logic done_out
);

  logic [1:0]  s;
  gate_state_t state;

`ifdef PARKING_SENSOR_SYNC_EN
  logic [1:0] sync_q1;
  logic [1:0] sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {a, b};
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = {a, b};
`endif

  // Completion is flagged in the same cycle the final 00 is sampled
  assign done_in  = (state == IN_B)  && (s == S_NONE);
  assign done_out = (state == OUT_A) && (s == S_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (s == S_A)      state <= IN_A;
          else if (s == S_B) state <= OUT_B;
          else               state <= IDLE;
        end
        IN_A: begin
          case (s)
            S_AB:    state <= IN_AB;
            S_A:     state <= IN_A;
            default: state <= IDLE;
          endcase
        end
        IN_AB: begin
          case (s)
            S_B:     state <= IN_B;
            S_A:     state <= IN_A;
            S_AB:    state <= IN_AB;
            default: state <= IDLE;
          endcase
        end
        IN_B: begin
          case (s)
            S_AB:    state <= IN_AB;
            S_B:     state <= IN_B;
            default: state <= IDLE;
          endcase
        end
        OUT_B: begin
          case (s)
            S_AB:    state <= OUT_BA;
            S_B:     state <= OUT_B;
            default: state <= IDLE;
          endcase
        end
        OUT_BA: begin
          case (s)
            S_A:     state <= OUT_A;
            S_B:     state <= OUT_B;
            S_AB:    state <= OUT_BA;
            default: state <= IDLE;
          endcase
        end
        OUT_A: begin
          case (s)
            S_AB:    state <= OUT_BA;
            S_A:     state <= OUT_A;
            default: state <= IDLE;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_multigate.sv
// Multi-gate parking-lot occupancy counter with shared arbiter.
// Optional sensor synchronisers enabled by PARKING_SENSOR_SYNC_EN.
module parking_lot_multigate
  import parking_pkg::*;
#(
  parameter int unsigned NUM_GATES = 2,
  parameter int unsigned CAPACITY  = 7,
  localparam int unsigned CW       = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] sensor_a,
  input  logic [NUM_GATES-1:0] sensor_b,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_GATES-1:0] entry_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [NUM_GATES-1:0] reject_pulse,
  output logic [NUM_GATES-1:0] phantom_pulse
);

  localparam logic [CW-1:0] CAP_V = CW'(CAPACITY);

  logic [NUM_GATES-1:0] done_in;
  logic [NUM_GATES-1:0] done_out;
  logic [NUM_GATES-1:0] entry_acc;
  logic [NUM_GATES-1:0] exit_acc;
  logic [NUM_GATES-1:0] reject_flag;
  logic [NUM_GATES-1:0] phantom_flag;
  logic [CW-1:0]        occ;

  for (genvar g = 0; g < NUM_GATES; g++) begin : gen_gate
    parking_gate_fsm u_gate (
      .clk      (clk),
      .reset    (reset),
      .a        (sensor_a[g]),
      .b        (sensor_b[g]),
      .done_in  (done_in[g]),
      .done_out (done_out[g])
    );
  end

  // Exits are applied before entries so a full lot can swap cars in one cycle
  always_comb begin
    occ          = count;
    entry_acc    = '0;
    exit_acc     = '0;
    reject_flag  = '0;
    phantom_flag = '0;
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      if (done_out[g]) begin
        if (occ != '0) begin
          occ         = occ - 1'b1;
          exit_acc[g] = 1'b1;
        end else begin
          phantom_flag[g] = 1'b1;
        end
      end
    end
    for (int unsigned g = 0; g < NUM_GATES; g++) begin
      if (done_in[g]) begin
        if (occ < CAP_V) begin
          occ          = occ + 1'b1;
          entry_acc[g] = 1'b1;
        end else begin
          reject_flag[g] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      entry_pulse   <= '0;
      exit_pulse    <= '0;
      reject_pulse  <= '0;
      phantom_pulse <= '0;
    end else begin
      count         <= occ;
      entry_pulse   <= entry_acc;
      exit_pulse    <= exit_acc;
      reject_pulse  <= reject_flag;
      phantom_pulse <= phantom_flag;
    end
  end

  assign full  = (count == CAP_V);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_lot_multigate.sv
// Self-checking bench: scripted/random car passages against a passage-level occupancy model.
module tb_parking_lot_multigate;

  localparam int NG  = 2;
  localparam int CAP = 7;
  localparam int CW  = $clog2(CAP + 1);
`ifdef PARKING_SENSOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int QD = 64;

  logic          clk;
  logic          reset;
  logic [NG-1:0] sensor_a;
  logic [NG-1:0] sensor_b;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [NG-1:0] entry_pulse;
  logic [NG-1:0] exit_pulse;
  logic [NG-1:0] reject_pulse;
  logic [NG-1:0] phantom_pulse;

  parking_lot_multigate #(.NUM_GATES(NG), .CAPACITY(CAP)) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_a      (sensor_a),
    .sensor_b      (sensor_b),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .entry_pulse   (entry_pulse),
    .exit_pulse    (exit_pulse),
    .reject_pulse  (reject_pulse),
    .phantom_pulse (phantom_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Per-gate scripted sensor codes {a,b} and the passage outcome tied to each code
  // (0 none, 1 entry completes here, 2 exit completes here)
  logic [1:0] cq [NG][QD];
  int         ev [NG][QD];
  int         qlen [NG];
  int         qpos [NG];
  bit         auto_mode;

  logic [NG-1:0] pipe_in  [3];
  logic [NG-1:0] pipe_out [3];

  int            exp_count;
  logic [NG-1:0] exp_entry, exp_exit, exp_rej, exp_ph;
  int            obs_entry [NG];
  int            obs_exit  [NG];
  int            obs_rej   [NG];
  int            obs_ph    [NG];

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic push(input int g, input logic [1:0] code, input int e);
    if (qlen[g] < QD) begin
      cq[g][qlen[g]] = code;
      ev[g][qlen[g]] = e;
      qlen[g]++;
    end
  endtask

  // Load a whole passage for one gate; each code held 1..maxrep cycles, closed by one 00
  task automatic load(input int g, input int kind, input int maxrep, input bit idles);
    logic [1:0] seq [6];
    int n;
    int e;
    if (qpos[g] == qlen[g]) begin
      qpos[g] = 0;
      qlen[g] = 0;
    end
    n = 0;
    e = 0;
    case (kind)
      0: begin seq[0]=2'b10; seq[1]=2'b11; seq[2]=2'b01; n=3; e=1; end
      1: begin seq[0]=2'b01; seq[1]=2'b11; seq[2]=2'b10; n=3; e=2; end
      2: begin seq[0]=2'b10; seq[1]=2'b11; seq[2]=2'b10; n=3; e=0; end
      3: begin seq[0]=2'b10; seq[1]=2'b11; seq[2]=2'b01; seq[3]=2'b11; seq[4]=2'b01; n=5; e=1; end
      4: begin seq[0]=2'b01; seq[1]=2'b11; seq[2]=2'b10; seq[3]=2'b11; seq[4]=2'b10; n=5; e=2; end
      5: begin seq[0]=2'b11; n=1; e=0; end
      6: begin seq[0]=2'b10; n=1; e=0; end
      default: begin seq[0]=2'b01; seq[1]=2'b11; seq[2]=2'b01; n=3; e=0; end
    endcase
    for (int i = 0; i < n; i++) begin
      int rep;
      rep = (maxrep > 1) ? int'($urandom_range(1, maxrep)) : 1;
      for (int r = 0; r < rep; r++) push(g, seq[i], 0);
    end
    push(g, 2'b00, e);
    if (idles) begin
      int k;
      k = int'($urandom_range(0, 2));
      for (int r = 0; r < k; r++) push(g, 2'b00, 0);
    end
  endtask

  task automatic clr_obs();
    for (int g = 0; g < NG; g++) begin
      obs_entry[g] = 0; obs_exit[g] = 0; obs_rej[g] = 0; obs_ph[g] = 0;
    end
  endtask

  // One cycle: compare outputs produced by the last edge, then drive and predict the next
  task automatic step();
    logic [NG-1:0] ein, eout, di, dox, sa, sb;
    int occ;
    @(negedge clk);
    chk("count", int'(count), exp_count);
    chk("full", int'(full), int'(exp_count == CAP));
    chk("empty", int'(empty), int'(exp_count == 0));
    chk("entry_pulse", int'(entry_pulse), int'(exp_entry));
    chk("exit_pulse", int'(exit_pulse), int'(exp_exit));
    chk("reject_pulse", int'(reject_pulse), int'(exp_rej));
    chk("phantom_pulse", int'(phantom_pulse), int'(exp_ph));
    for (int g = 0; g < NG; g++) begin
      obs_entry[g] += int'(entry_pulse[g]);
      obs_exit[g]  += int'(exit_pulse[g]);
      obs_rej[g]   += int'(reject_pulse[g]);
      obs_ph[g]    += int'(phantom_pulse[g]);
    end
    ein = '0; eout = '0; sa = '0; sb = '0;
    for (int g = 0; g < NG; g++) begin
      if (auto_mode && qpos[g] == qlen[g]) load(g, int'($urandom_range(0, 7)), 3, 1'b1);
      if (qpos[g] < qlen[g]) begin
        sa[g]   = cq[g][qpos[g]][1];
        sb[g]   = cq[g][qpos[g]][0];
        ein[g]  = (ev[g][qpos[g]] == 1);
        eout[g] = (ev[g][qpos[g]] == 2);
        qpos[g]++;
      end
    end
    sensor_a = sa;
    sensor_b = sb;
    for (int i = LAT; i > 0; i--) begin
      pipe_in[i]  = pipe_in[i-1];
      pipe_out[i] = pipe_out[i-1];
    end
    pipe_in[0]  = ein;
    pipe_out[0] = eout;
    di  = pipe_in[LAT];
    dox = pipe_out[LAT];
    occ = exp_count;
    exp_entry = '0; exp_exit = '0; exp_rej = '0; exp_ph = '0;
    for (int g = 0; g < NG; g++)
      if (dox[g]) begin
        if (occ > 0) begin occ--; exp_exit[g] = 1'b1; end
        else exp_ph[g] = 1'b1;
      end
    for (int g = 0; g < NG; g++)
      if (di[g]) begin
        if (occ < CAP) begin occ++; exp_entry[g] = 1'b1; end
        else exp_rej[g] = 1'b1;
      end
    exp_count = occ;
  endtask

  task automatic drain();
    int budget;
    bit busy;
    budget = 300;
    busy = 1'b1;
    while (busy && budget > 0) begin
      busy = 1'b0;
      for (int g = 0; g < NG; g++) if (qpos[g] < qlen[g]) busy = 1'b1;
      if (busy) begin step(); budget--; end
    end
    if (busy) chk("drain_timeout", 1, 0);
    repeat (LAT + 2) step();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    sensor_a = '0;
    sensor_b = '0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_pulses", int'({entry_pulse, exit_pulse, reject_pulse, phantom_pulse}), 0);
    for (int g = 0; g < NG; g++) begin qpos[g] = 0; qlen[g] = 0; end
    for (int i = 0; i < 3; i++) begin pipe_in[i] = '0; pipe_out[i] = '0; end
    exp_count = 0;
    exp_entry = '0; exp_exit = '0; exp_rej = '0; exp_ph = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_seen;
    n_checks = 0;
    n_fail = 0;
    auto_mode = 1'b0;
    reset = 1'b0;
    sensor_a = '0;
    sensor_b = '0;
    for (int g = 0; g < NG; g++) begin qpos[g] = 0; qlen[g] = 0; end
    do_reset();
    repeat (2) step();

    // Single entry on gate 0, also pinning completion latency
    clr_obs();
    load(0, 0, 1, 1'b0);
    lat_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (count == 1 && lat_seen == 0) lat_seen = i;
    end
    chk("entry_latency", lat_seen, 5 + LAT);
    chk("lit_count_1", int'(count), 1);
    chk("lit_empty_0", int'(empty), 0);
    chk("lit_entry0_once", obs_entry[0], 1);

    // Two more entries then asynchronous reset from count 3
    load(0, 0, 1, 1'b0); drain();
    load(1, 3, 1, 1'b0); drain();
    chk("lit_count_3", int'(count), 3);
    do_reset();
    repeat (2) step();

    // Exit on empty lot is phantom; backed-out entry produces nothing
    clr_obs();
    load(1, 1, 1, 1'b0); drain();
    chk("lit_phantom1_once", obs_ph[1], 1);
    chk("lit_count_0_after_phantom", int'(count), 0);
    clr_obs();
    load(1, 2, 1, 1'b0); drain();
    chk("lit_backout_quiet", obs_entry[1] + obs_exit[1] + obs_rej[1] + obs_ph[1], 0);

    // Fill to capacity then one more
    clr_obs();
    for (int k = 0; k < CAP + 1; k++) begin load(0, 0, 1, 1'b0); drain(); end
    chk("lit_count_full", int'(count), CAP);
    chk("lit_full_flag", int'(full), 1);
    chk("lit_reject0_once", obs_rej[0], 1);
    chk("lit_entries_at_fill", obs_entry[0], CAP);

    // Simultaneous exit(g0) and entry(g1) at full
    clr_obs();
    load(0, 1, 1, 1'b0); load(1, 0, 1, 1'b0); drain();
    chk("lit_full_swap_exit0", obs_exit[0], 1);
    chk("lit_full_swap_entry1", obs_entry[1], 1);
    chk("lit_full_swap_count", int'(count), CAP);

    // Same at empty
    do_reset();
    clr_obs();
    load(0, 1, 1, 1'b0); load(1, 0, 1, 1'b0); drain();
    chk("lit_empty_swap_ph0", obs_ph[0], 1);
    chk("lit_empty_swap_entry1", obs_entry[1], 1);
    chk("lit_empty_swap_count", int'(count), 1);

    // Randomised passages on all gates, with one reset mid-traffic
    auto_mode = 1'b1;
    repeat (1500) step();
    do_reset();
    repeat (1500) step();
    auto_mode = 1'b0;
    for (int g = 0; g < NG; g++) qpos[g] = qlen[g];
    repeat (LAT + 3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_lot_multigate.md
Name: parking_lot_multigate

Overview:
- Parametrised successor to the single-gate parking-lot counter.
- Tracks occupancy of one lot served by NUM_GATES bidirectional gates, each with an outer sensor A and an inner sensor B.
- Each gate runs its own direction-decoding FSM. A shared arbiter applies all same-cycle entry/exit events to one saturating occupancy counter of configurable capacity.
- Outputs full/empty flags and per-gate event, reject and phantom-exit pulses for barrier and display logic.

Parameters:
- NUM_GATES, 2, number of gates (1..8).
- CAPACITY, 7, maximum cars (1..255).
- CW, $clog2(CAPACITY+1), count width. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sensor_a  in  NUM_GATES  outer sensor per gate, 1 = beam blocked.
- sensor_b  in  NUM_GATES  inner sensor per gate, 1 = beam blocked.
- count  out  CW  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- entry_pulse  out  NUM_GATES  1-cycle pulse per accepted entry.
- exit_pulse  out  NUM_GATES  1-cycle pulse per accepted exit.
- reject_pulse  out  NUM_GATES  1-cycle pulse: entry completed while no space.
- phantom_pulse  out  NUM_GATES  1-cycle pulse: exit completed while lot empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - All gate FSMs go to IDLE.
  - count=0, empty=1, full=0.
  - All pulse outputs 0.
  - Reset mid-sequence discards partial passages.
- Gate FSM states, with sensors written as {a,b}:
  - IDLE: 10->IN_A; 01->OUT_B; 11 and 00 stay in IDLE (11 from IDLE is ignored as illegal).
  - IN_A: 11->IN_AB; 00->IDLE (abort); 10 stays; 01->IDLE.
  - IN_AB: 01->IN_B; 10->IN_A (backing out); 00->IDLE; 11 stays.
  - IN_B: 00->IDLE and raise done_in; 11->IN_AB; 01 stays; 10->IDLE.
  - OUT_B / OUT_BA / OUT_A: mirror of the above with a and b swapped. OUT_A seeing 00 raises done_out.
- done_in and done_out are combinational, valid in the cycle the FSM samples 00 in its final state.
- Arbitration, evaluated every cycle on the done_* vectors:
  - occ starts at count.
  - Exits are processed by ascending gate index: accept if occ>0 and decrement; otherwise flag phantom.
  - Entries are then processed by ascending gate index: accept if occ<CAPACITY and increment; otherwise flag reject.
  - count <= occ at the same clock edge that the FSMs return to IDLE.
- Latency:
  - count, full and empty update at the edge where 00 is sampled in the final state.
  - entry/exit/reject/phantom pulses are registered and asserted for exactly the following cycle (aligned with the new count).
- Boundary cases:
  - count never wraps.
  - At full, a simultaneous exit on one gate and entry on another are both accepted; count is unchanged.
  - At empty, a simultaneous exit and entry give: exit phantom, entry accepted, count=1.
  - full and empty are decoded from registered count (glitch-free).

Optional Feature:
- Macro: PARKING_SENSOR_SYNC_EN.
- Defined: a 2-flop synchroniser is inserted on every sensor_a/sensor_b bit, reset to 0. All event and count latencies grow by 2 cycles.
- Undefined: sensors feed the FSMs directly; the inputs are assumed already synchronous to clk.

Decomposition:
- Shared package parking_pkg:
  - gate-state enum/localparams (IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A);
  - sensor-code constants S_NONE=00, S_A=10, S_AB=11, S_B=01.
- One natural sub-module: parking_gate_fsm (per-gate FSM plus optional synchroniser). It is instantiated NUM_GATES times via generate.
- Arbiter and counter stay in the top level.

Test Plan:
- Reset with count at 3 -> count=0, empty=1, full=0, all pulses 0, asynchronously before the next edge.
- Gate0 sequence 10,11,01,00 (1 cycle each) from count=0 -> entry_pulse[0] high for one cycle; count=1, empty=0.
- Gate1 sequence 01,11,10,00 at count=0 -> phantom_pulse[1] pulses once, count stays 0. Sequence 10,11,10,00 (backed out) -> no pulse.
- CAPACITY=7: 7 entries on gate0, then an 8th -> count=7, full=1, reject_pulse[0] pulses, count stays 7.
- At count=7: gate0 exit and gate1 entry complete in the same cycle -> exit_pulse[0] and entry_pulse[1] both pulse, count=7. Repeat at count=0 with gate0 exit and gate1 entry -> phantom_pulse[0] and entry_pulse[1], count=1.
- PARKING_SENSOR_SYNC_EN defined: a gate0 entry shows count increment exactly 2 cycles later than the unsynchronised build.
